// File: rtl/char_tile_tracker.sv
// Character-tile tracker: follows the VGA raster from pixel-tick / line-start /
// frame-start events and produces registered tile coordinates, glyph offsets,
// a linear text-buffer address, area detection and a blinking cursor match.
// Positions are kept as small wrap counters plus a row-base accumulator, so
// no comparator chains, dividers or multipliers are needed for any tile size.
// The output stage has one cycle of latency: out_valid=1 marks the cycle after
// a pixel_tick, and all other outputs hold their values between ticks.
module char_tile_tracker #(
  parameter int H_PIX        = 640,
  parameter int V_PIX        = 480,
  parameter int TILE_W       = 8,
  parameter int TILE_H       = 16,
  parameter int XW           = 7,
  parameter int YW           = 5,
  parameter int AW           = 12,
  parameter int BLINK_FRAMES = 30,
  localparam int GXW = (TILE_W > 1) ? $clog2(TILE_W) : 1,
  localparam int GYW = (TILE_H > 1) ? $clog2(TILE_H) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pixel_tick,
  input  logic           frame_start,
  input  logic           line_start,
  input  logic           active,
  input  logic           cursor_en,
  input  logic [XW-1:0]  cursor_x,
  input  logic [YW-1:0]  cursor_y,
  output logic           out_valid,
  output logic [XW-1:0]  char_tile_x,
  output logic [YW-1:0]  char_tile_y,
  output logic [GXW-1:0] glyph_col,
  output logic [GYW-1:0] glyph_row,
  output logic [AW-1:0]  text_addr,
  output logic           in_area,
  output logic           cursor_hit,
  output logic           blink_phase
);

  localparam int COLS = H_PIX / TILE_W;
  localparam int ROWS = V_PIX / TILE_H;
  localparam int FCW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [GXW-1:0] SUB_X_LAST = GXW'(TILE_W - 1);
  localparam logic [GYW-1:0] SUB_Y_LAST = GYW'(TILE_H - 1);
  localparam logic [XW-1:0]  COLS_X     = XW'(COLS);
  localparam logic [YW-1:0]  ROWS_Y     = YW'(ROWS);
  localparam logic [AW-1:0]  COLS_A     = AW'(COLS);
  localparam logic [FCW-1:0] FC_LAST    = FCW'(BLINK_FRAMES - 1);

  // Position of the next pixel (x part) and of the current line (y part).
  logic [GXW-1:0] sub_x;
  logic [XW-1:0]  tile_x;
  logic [GYW-1:0] sub_y;
  logic [YW-1:0]  tile_y;
  logic [AW-1:0]  row_base;
  logic [FCW-1:0] frame_cnt;

  // Position of the ticked pixel P.
  logic [GXW-1:0] p_sub_x;
  logic [XW-1:0]  p_tile_x;
  logic [GYW-1:0] p_sub_y;
  logic [YW-1:0]  p_tile_y;
  logic [AW-1:0]  p_row_base;

  // Successor column state and per-pixel results.
  logic [GXW-1:0] n_sub_x;
  logic [XW-1:0]  n_tile_x;
  logic [FCW-1:0] n_frame_cnt;
  logic           n_blink;
  logic           p_in_area;
  logic           p_hit;
  logic [AW-1:0]  p_addr;

  // Resolve the ticked pixel's position: frame_start beats line_start beats stored.
  always_comb begin
    p_sub_x    = sub_x;
    p_tile_x   = tile_x;
    p_sub_y    = sub_y;
    p_tile_y   = tile_y;
    p_row_base = row_base;
    if (frame_start) begin
      p_sub_x    = '0;
      p_tile_x   = '0;
      p_sub_y    = '0;
      p_tile_y   = '0;
      p_row_base = '0;
    end else if (line_start) begin
      p_sub_x  = '0;
      p_tile_x = '0;
      if (sub_y == SUB_Y_LAST) begin
        p_sub_y = '0;
        // Rows saturate at ROWS; the row base freezes with them.
        if (tile_y != ROWS_Y) begin
          p_tile_y   = tile_y + YW'(1);
          p_row_base = row_base + COLS_A;
        end
      end else begin
        p_sub_y = sub_y + GYW'(1);
      end
    end
  end

  // Column advance after an active pixel, saturating one past the last tile.
  always_comb begin
    n_sub_x  = p_sub_x;
    n_tile_x = p_tile_x;
    if (active) begin
      if (p_tile_x == COLS_X) begin
        n_sub_x = '0;
      end else if (p_sub_x == SUB_X_LAST) begin
        n_sub_x  = '0;
        n_tile_x = p_tile_x + XW'(1);
      end else begin
        n_sub_x = p_sub_x + GXW'(1);
      end
    end
  end

  // Blink counter step on frame_start, area test, address and cursor match.
  always_comb begin
    n_frame_cnt = frame_cnt;
    n_blink     = blink_phase;
    if (frame_start) begin
      if (frame_cnt == FC_LAST) begin
        n_frame_cnt = '0;
        n_blink     = ~blink_phase;
      end else begin
        n_frame_cnt = frame_cnt + FCW'(1);
      end
    end
    p_in_area = active && (p_tile_x < COLS_X) && (p_tile_y < ROWS_Y);
    p_addr    = p_row_base + AW'(p_tile_x);
    p_hit     = p_in_area && cursor_en && n_blink &&
                (p_tile_x == cursor_x) && (p_tile_y == cursor_y);
  end

  // Position state and registered outputs; everything but out_valid holds between ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_x       <= '0;
      tile_x      <= '0;
      sub_y       <= '0;
      tile_y      <= '0;
      row_base    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
      out_valid   <= 1'b0;
      in_area     <= 1'b0;
      cursor_hit  <= 1'b0;
      char_tile_x <= '0;
      char_tile_y <= '0;
      glyph_col   <= '0;
      glyph_row   <= '0;
      text_addr   <= '0;
    end else begin
      out_valid <= pixel_tick;
      if (pixel_tick) begin
        sub_x       <= n_sub_x;
        tile_x      <= n_tile_x;
        sub_y       <= p_sub_y;
        tile_y      <= p_tile_y;
        row_base    <= p_row_base;
        frame_cnt   <= n_frame_cnt;
        blink_phase <= n_blink;
        in_area     <= p_in_area;
        cursor_hit  <= p_hit;
        char_tile_x <= p_in_area ? p_tile_x : '0;
        char_tile_y <= p_in_area ? p_tile_y : '0;
        glyph_col   <= p_in_area ? p_sub_x : '0;
        glyph_row   <= p_in_area ? p_sub_y : '0;
        text_addr   <= p_in_area ? p_addr : '0;
      end
    end
  end

endmodule

// File: tb/tb_char_tile_tracker.sv
// Bench for char_tile_tracker: two instances (640x480 with 8x16 tiles, and a
// 60x30 grid of 6x10 tiles) share one raster stream. A pixel-coordinate
// reference model predicts every output cycle; directed points add fixed checks.
module tb_char_tile_tracker;

  // Clock / reset.
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Shared stimulus.
  logic       pixel_tick, frame_start, line_start, active, cursor_en;
  logic [6:0] cx0;
  logic [4:0] cy0;
  logic [3:0] cx1;
  logic [1:0] cy1;

  // Instance 0 outputs.
  logic        ov0, ia0, hit0, bp0;
  logic [6:0]  ctx0;
  logic [4:0]  cty0;
  logic [2:0]  gc0;
  logic [3:0]  gr0;
  logic [11:0] ta0;

  // Instance 1 outputs.
  logic       ov1, ia1, hit1, bp1;
  logic [3:0] ctx1;
  logic [1:0] cty1;
  logic [2:0] gc1;
  logic [3:0] gr1;
  logic [4:0] ta1;

  char_tile_tracker #(.H_PIX(640), .V_PIX(480), .TILE_W(8), .TILE_H(16),
                      .XW(7), .YW(5), .AW(12), .BLINK_FRAMES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick),
    .frame_start(frame_start), .line_start(line_start), .active(active),
    .cursor_en(cursor_en), .cursor_x(cx0), .cursor_y(cy0),
    .out_valid(ov0), .char_tile_x(ctx0), .char_tile_y(cty0),
    .glyph_col(gc0), .glyph_row(gr0), .text_addr(ta0),
    .in_area(ia0), .cursor_hit(hit0), .blink_phase(bp0)
  );

  char_tile_tracker #(.H_PIX(60), .V_PIX(30), .TILE_W(6), .TILE_H(10),
                      .XW(4), .YW(2), .AW(5), .BLINK_FRAMES(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick),
    .frame_start(frame_start), .line_start(line_start), .active(active),
    .cursor_en(cursor_en), .cursor_x(cx1), .cursor_y(cy1),
    .out_valid(ov1), .char_tile_x(ctx1), .char_tile_y(cty1),
    .glyph_col(gc1), .glyph_row(gr1), .text_addr(ta1),
    .in_area(ia1), .cursor_hit(hit1), .blink_phase(bp1)
  );

  // Packed view: {valid, in_area, hit, phase, tx[8], ty[8], gcol[4], grow[4], addr[12]}.
  logic [39:0] obs0, obs1;
  assign obs0 = {ov0, ia0, hit0, bp0, 8'(ctx0), 8'(cty0), 4'(gc0), 4'(gr0), 12'(ta0)};
  assign obs1 = {ov1, ia1, hit1, bp1, 8'(ctx1), 8'(cty1), 4'(gc1), 4'(gr1), 12'(ta1)};
  localparam logic [39:0] RESET_EXP = 40'h10_0000_0000;

  // Scoreboard.
  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q0[$];
  logic [39:0] exp_q1[$];

  // Reference model state, in plain pixel coordinates.
  int          xn[2];
  int          yl[2];
  int          nfr[2];
  logic [39:0] last[2];

  function automatic int g_hp(input int k); return (k == 0) ? 640 : 60; endfunction
  function automatic int g_vp(input int k); return (k == 0) ? 480 : 30; endfunction
  function automatic int g_tw(input int k); return (k == 0) ? 8 : 6;    endfunction
  function automatic int g_th(input int k); return (k == 0) ? 16 : 10;  endfunction
  function automatic int g_bf(input int k); return (k == 0) ? 2 : 3;    endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      xn[k]   = 0;
      yl[k]   = 0;
      nfr[k]  = 0;
      last[k] = RESET_EXP;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Predict the outputs one tick produces, from absolute x/y coordinates.
  task automatic model(input int k, input logic tk, input logic fs, input logic ls,
                       input logic act);
    int x, y, tx, ty, gc, gr, ad, cx, cy, cols;
    logic ia, hit, ph;
    if (!tk) begin
      last[k][39] = 1'b0;
      return;
    end
    if (fs) begin
      x = 0; y = 0; nfr[k]++;
    end else if (ls) begin
      x = 0; y = yl[k] + 1;
    end else begin
      x = xn[k]; y = yl[k];
    end
    cols = g_hp(k) / g_tw(k);
    cx   = (k == 0) ? int'(cx0) : int'(cx1);
    cy   = (k == 0) ? int'(cy0) : int'(cy1);
    ia   = act && (x < g_hp(k)) && (y < g_vp(k));
    ph   = ((nfr[k] / g_bf(k)) % 2) == 0;
    tx = 0; ty = 0; gc = 0; gr = 0; ad = 0;
    if (ia) begin
      tx = x / g_tw(k);
      ty = y / g_th(k);
      gc = x % g_tw(k);
      gr = y % g_th(k);
      ad = ty * cols + tx;
    end
    hit = ia && cursor_en && ph && (tx == cx) && (ty == cy);
    if (act) xn[k] = (x < g_hp(k)) ? x + 1 : g_hp(k);
    else     xn[k] = x;
    yl[k]   = y;
    last[k] = {1'b1, ia, hit, ph, 8'(tx), 8'(ty), 4'(gc), 4'(gr), 12'(ad)};
  endtask

  // Driver: apply inputs at a falling edge, check both instances at the next one.
  task automatic step(input logic tk, input logic fs, input logic ls, input logic act);
    logic [39:0] e0, e1;
    pixel_tick  = tk;
    frame_start = fs;
    line_start  = ls;
    active      = act;
    model(0, tk, fs, ls, act);
    model(1, tk, fs, ls, act);
    exp_q0.push_back(last[0]);
    exp_q1.push_back(last[1]);
    @(posedge clk);
    @(negedge clk);
    e0 = exp_q0.pop_front();
    e1 = exp_q1.pop_front();
    chk("dut0_outputs", obs0, e0);
    chk("dut1_outputs", obs1, e1);
  endtask

  // One pixel, sometimes preceded by an idle cycle carrying junk qualifiers.
  task automatic px(input logic fs, input logic ls, input logic act);
    if ($urandom_range(0, 7) == 0)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b1, fs, ls, act);
  endtask

  // A line of n ticks opened by frame_start or line_start.
  task automatic line(input int n, input bit first_fs, input bit rnd);
    for (int i = 0; i < n; i++)
      px(1'(i == 0 && first_fs), 1'(i == 0 && !first_fs),
         rnd ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  int hit_tab[7] = '{0, 1, 1, 0, 0, 1, 0};

  initial begin
    reset_n = 1'b0;
    pixel_tick = 1'b0; frame_start = 1'b0; line_start = 1'b0; active = 1'b0;
    cursor_en = 1'b0; cx0 = '0; cy0 = '0; cx1 = '0; cy1 = '0;
    model_reset();
    @(negedge clk);
    chk("reset_dut0", obs0, RESET_EXP);
    chk("reset_dut1", obs1, RESET_EXP);
    reset_n = 1'b1;
    @(negedge clk);

    // First pixels of a frame.
    px(1'b1, 1'b0, 1'b1);
    chk_int("tick1_valid", int'(ov0), 1);
    chk_int("tick1_addr", int'(ta0), 0);
    chk_int("tick1_phase", int'(bp0), 1);
    for (int i = 0; i < 8; i++) px(1'b0, 1'b0, 1'b1);
    chk_int("tick9_tile_x", int'(ctx0), 1);
    chk_int("tick9_glyph_col", int'(gc0), 0);
    chk_int("tick9_addr", int'(ta0), 1);
    px(1'b0, 1'b0, 1'b1);
    chk_int("tick10_glyph_col", int'(gc0), 1);

    // Full-height raster with short filler lines and long lines where it matters.
    cursor_en = 1'b1; cx0 = 7'd5; cy0 = 5'd2; cx1 = 4'd3; cy1 = 2'd1;
    line(60, 1'b1, 1'b0);
    for (int y = 1; y <= 483; y++) begin
      if (y == 16) begin
        line(9, 1'b0, 1'b0);
        chk_int("pix_8_16_addr", int'(ta0), 81);
        for (int i = 0; i < 51; i++) px(1'b0, 1'b0, 1'b1);
      end else if (y <= 29) begin
        line(60, 1'b0, 1'b0);
        if (y == 29) begin
          chk_int("small_tile_x", int'(ctx1), 9);
          chk_int("small_tile_y", int'(cty1), 2);
          chk_int("small_glyph_col", int'(gc1), 5);
          chk_int("small_glyph_row", int'(gr1), 9);
          chk_int("small_addr", int'(ta1), 29);
        end
      end else if (y >= 32 && y <= 47) begin
        line(48, 1'b0, 1'b0);
      end else if (y == 479) begin
        line(640, 1'b0, 1'b0);
        chk_int("last_tile_x", int'(ctx0), 79);
        chk_int("last_tile_y", int'(cty0), 29);
        chk_int("last_glyph_col", int'(gc0), 7);
        chk_int("last_glyph_row", int'(gr0), 15);
        chk_int("last_addr", int'(ta0), 2399);
        for (int i = 0; i < 8; i++) px(1'b0, 1'b0, 1'b1);
        chk_int("overrun_in_area", int'(ia0), 0);
        chk_int("overrun_tile_x", int'(ctx0), 0);
        chk_int("overrun_addr", int'(ta0), 0);
      end else if (y >= 480) begin
        line(2, 1'b0, 1'b0);
        if (y == 480) chk_int("line481_in_area", int'(ia0), 0);
      end else begin
        line($urandom_range(1, 4), 1'b0, 1'b1);
      end
    end

    // Blink frames: cursor at tile (5,2), enable dropped in the last frame.
    for (int f = 0; f < 7; f++) begin
      cursor_en = 1'(f < 6);
      if (f == 6) cx0 = 7'($urandom_range(0, 127));
      cx1 = 4'($urandom_range(0, 15));
      cy1 = 2'($urandom_range(0, 3));
      line(4, 1'b1, 1'b0);
      for (int y = 1; y <= 47; y++) begin
        if (y == 32) begin
          line(41, 1'b0, 1'b0);
          chk_int("blink_cursor_hit", int'(hit0), hit_tab[f]);
          for (int i = 0; i < 7; i++) px(1'b0, 1'b0, 1'b1);
        end else if (y > 32) begin
          line(48, 1'b0, 1'b0);
        end else begin
          line($urandom_range(1, 20), 1'b0, 1'b1);
        end
      end
    end

    // Reset in the middle of a line, then resume without frame_start.
    cursor_en = 1'b1; cx0 = 7'd0; cy0 = 5'd0; cx1 = 4'd0; cy1 = 2'd0;
    line(5, 1'b1, 1'b0);
    line(13, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_dut0", obs0, RESET_EXP);
    chk("midreset_dut1", obs1, RESET_EXP);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    px(1'b0, 1'b0, 1'b1);
    chk_int("post_reset_tile_x", int'(ctx0), 0);
    chk_int("post_reset_glyph_col", int'(gc0), 0);
    for (int i = 0; i < 10; i++) px(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    line(7, 1'b0, 1'b1);
    px(1'b1, 1'b0, 1'b1);
    chk_int("post_reset_fs_phase", int'(bp0), 1);
    chk_int("post_reset_fs_addr", int'(ta0), 0);
    for (int i = 0; i < 20; i++) px(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
